pipe_gearbox_fifo: RTL

- Parametrised single-clock FIFO with an asymmetric-width gearbox and built-in block throttle flags.
- Supersedes the fixed 32→256 and 64→32 pipe FIFOs and the separate block-throttle logic around the pattern engine.
- MODE selects the direction:
  - pack: narrow write, wide read (pipe-in side).
  - unpack: wide write, narrow read (pipe-out side).
- Block-ready flags tell the host pipe when a full block can be transferred.

---
 rtl/pipe_fifo_pkg.sv | 16 +
 rtl/pipe_fifo_ctrl.sv | 105 ++++++++++
 rtl/pipe_gearbox_fifo.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_fifo_pkg.sv
// Shared constants and helpers for the asymmetric-width pipe FIFO.
// Narrow lane 0 is the most significant lane of a wide word.
package pipe_fifo_pkg;

    localparam int MODE_PACK   = 0;
    localparam int MODE_UNPACK = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int lane_off(input int idx, input int w_n, input int ratio);
        return (ratio - 1 - idx) * w_n;
    endfunction

endpackage

// File: rtl/pipe_fifo_ctrl.sv
// Occupancy, pointers, registered flags, counts and block throttle.
// Every flag is computed from next-state occupancy, so it is exact one edge later.
module pipe_fifo_ctrl
    import pipe_fifo_pkg::*;
#(
    parameter int DEPTH_N = 1024,
    parameter int RATIO   = 8,
    parameter int MODE    = 0,
    parameter int BLOCK_N = 128,
    localparam int WR_SZ  = (MODE == MODE_PACK) ? 1 : RATIO,
    localparam int RD_SZ  = (MODE == MODE_PACK) ? RATIO : 1,
    localparam int PW     = $clog2(DEPTH_N),
    localparam int WCW    = cnt_w(DEPTH_N / WR_SZ),
    localparam int RCW    = cnt_w(DEPTH_N / RD_SZ)
) (
    input  logic           okClk,
    input  logic           reset,
    input  logic           wr_en,
    input  logic           rd_en,
    output logic           wr_acc,
    output logic           rd_acc,
    output logic [PW-1:0]  wr_ptr,
    output logic [PW-1:0]  rd_ptr,
    output logic           full,
    output logic           empty,
    output logic [WCW-1:0] wr_data_count,
    output logic [RCW-1:0] rd_data_count,
    output logic           in_block_ready,
    output logic           out_block_ready,
    output logic           overflow,
    output logic           underflow
);

    localparam int OCW    = PW + 1;
    localparam int WR_SH  = $clog2(WR_SZ);
    localparam int RD_SH  = $clog2(RD_SZ);
    localparam int BLK_RD = BLOCK_N / RD_SZ;

    logic           wr_acc_s, rd_acc_s;
    logic [OCW-1:0] occ_r, occ_nxt_s, free_nxt_s;
    logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
    logic           full_r, empty_r, in_blk_r, out_blk_r, ovf_r, unf_r;
    logic [WCW-1:0] wr_cnt_r;
    logic [RCW-1:0] rd_cnt_r;

    // acceptance and next occupancy in narrow units
    always_comb begin
        wr_acc_s  = wr_en && !full_r;
        rd_acc_s  = rd_en && !empty_r;
        occ_nxt_s = occ_r;
        if (wr_acc_s && rd_acc_s) begin
            occ_nxt_s = occ_r + OCW'(WR_SZ) - OCW'(RD_SZ);
        end else if (wr_acc_s) begin
            occ_nxt_s = occ_r + OCW'(WR_SZ);
        end else if (rd_acc_s) begin
            occ_nxt_s = occ_r - OCW'(RD_SZ);
        end else begin
            occ_nxt_s = occ_r;
        end
        free_nxt_s = OCW'(DEPTH_N) - occ_nxt_s;
    end

    // state and registered status outputs
    always_ff @(posedge okClk or negedge reset) begin
        if (!reset) begin
            occ_r     <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            wr_cnt_r  <= '0;
            rd_cnt_r  <= '0;
            in_blk_r  <= 1'b1;
            out_blk_r <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            occ_r     <= occ_nxt_s;
            wr_ptr_r  <= wr_acc_s ? wr_ptr_r + PW'(WR_SZ) : wr_ptr_r;
            rd_ptr_r  <= rd_acc_s ? rd_ptr_r + PW'(RD_SZ) : rd_ptr_r;
            full_r    <= free_nxt_s < OCW'(WR_SZ);
            empty_r   <= occ_nxt_s < OCW'(RD_SZ);
            wr_cnt_r  <= WCW'(occ_nxt_s >> WR_SH);
            rd_cnt_r  <= RCW'(occ_nxt_s >> RD_SH);
            in_blk_r  <= free_nxt_s >= OCW'(BLOCK_N);
            out_blk_r <= (occ_nxt_s >> RD_SH) >= OCW'(BLK_RD);
            ovf_r     <= wr_en && full_r;
            unf_r     <= rd_en && empty_r;
        end
    end

    assign wr_acc          = wr_acc_s;
    assign rd_acc          = rd_acc_s;
    assign wr_ptr          = wr_ptr_r;
    assign rd_ptr          = rd_ptr_r;
    assign full            = full_r;
    assign empty           = empty_r;
    assign wr_data_count   = wr_cnt_r;
    assign rd_data_count   = rd_cnt_r;
    assign in_block_ready  = in_blk_r;
    assign out_block_ready = out_blk_r;
    assign overflow        = ovf_r;
    assign underflow       = unf_r;

endmodule

// File: rtl/pipe_gearbox_fifo.sv
// Single-clock FIFO with narrow/wide gearbox; storage is RATIO lane banks so a
// wide access touches one row of every bank and a narrow access one bank.
module pipe_gearbox_fifo
    import pipe_fifo_pkg::*;
#(
    parameter int W_N      = 32,
    parameter int RATIO    = 8,
    parameter int DEPTH_N  = 1024,
    parameter int MODE     = 0,
    parameter int BLOCK_N  = 128,
    localparam int W_W      = W_N * RATIO,
    localparam int W_WR     = (MODE == MODE_PACK) ? W_N : W_W,
    localparam int W_RD     = (MODE == MODE_PACK) ? W_W : W_N,
    localparam int DEPTH_WR = (MODE == MODE_PACK) ? DEPTH_N : DEPTH_N / RATIO,
    localparam int DEPTH_RD = (MODE == MODE_PACK) ? DEPTH_N / RATIO : DEPTH_N
) (
    input  logic                         okClk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [W_WR-1:0]              din,
    input  logic                         rd_en,
    output logic [W_RD-1:0]              dout,
    output logic                         valid,
    output logic                         full,
    output logic                         empty,
    output logic [cnt_w(DEPTH_WR)-1:0]   wr_data_count,
    output logic [cnt_w(DEPTH_RD)-1:0]   rd_data_count,
    output logic                         in_block_ready,
    output logic                         out_block_ready,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW   = $clog2(DEPTH_N);
    localparam int BW   = $clog2(RATIO);
    localparam int ROWS = DEPTH_N / RATIO;

    logic              wr_acc_s, rd_acc_s;
    logic [PW-1:0]     wr_ptr_s, rd_ptr_s;
    logic [PW-BW-1:0]  wr_row_s, rd_row_s;
    logic [BW-1:0]     wr_bank_s, rd_bank_s;
    logic [W_W-1:0]    din_w_s, rd_wide_s;
    logic [W_N-1:0]    rd_narrow_s;
    logic [W_N-1:0]    mem_r [RATIO][ROWS];
    logic [W_RD-1:0]   dout_r;
    logic              valid_r;

    pipe_fifo_ctrl #(
        .DEPTH_N (DEPTH_N),
        .RATIO   (RATIO),
        .MODE    (MODE),
        .BLOCK_N (BLOCK_N)
    ) u_ctrl (
        .okClk           (okClk),
        .reset           (reset),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .wr_acc          (wr_acc_s),
        .rd_acc          (rd_acc_s),
        .wr_ptr          (wr_ptr_s),
        .rd_ptr          (rd_ptr_s),
        .full            (full),
        .empty           (empty),
        .wr_data_count   (wr_data_count),
        .rd_data_count   (rd_data_count),
        .in_block_ready  (in_block_ready),
        .out_block_ready (out_block_ready),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    assign wr_row_s    = wr_ptr_s[PW-1:BW];
    assign wr_bank_s   = wr_ptr_s[BW-1:0];
    assign rd_row_s    = rd_ptr_s[PW-1:BW];
    assign rd_bank_s   = rd_ptr_s[BW-1:0];
    assign din_w_s     = W_W'(din);
    assign rd_narrow_s = mem_r[rd_bank_s][rd_row_s];

    // gather one row of all banks into a wide word, lane 0 at the top
    always_comb begin
        rd_wide_s = '0;
        for (int k = 0; k < RATIO; k++) begin
            rd_wide_s[lane_off(k, W_N, RATIO) +: W_N] = mem_r[k][rd_row_s];
        end
    end

    // storage write: all lanes for a wide word, one bank for a narrow word
    always_ff @(posedge okClk) begin
        if (wr_acc_s) begin
            for (int k = 0; k < RATIO; k++) begin
                if (MODE == MODE_UNPACK) begin
                    mem_r[k][wr_row_s] <= din_w_s[lane_off(k, W_N, RATIO) +: W_N];
                end else if (k == int'(wr_bank_s)) begin
                    mem_r[k][wr_row_s] <= din_w_s[W_N-1:0];
                end
            end
        end
    end

    // registered read data and valid, one cycle after an accepted read
    always_ff @(posedge okClk or negedge reset) begin
        if (!reset) begin
            dout_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                dout_r <= (MODE == MODE_PACK) ? W_RD'(rd_wide_s) : W_RD'(rd_narrow_s);
            end
        end
    end

    assign dout  = dout_r;
    assign valid = valid_r;

endmodule
